frame_tx: RTL
=============

FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 Parameter WIDTH SHALL default to 11 and set the frame width in bits, matching the upstream queue data width.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 16 and set the clk cycles each bit is held on tx (legal range 2..65535).
REQ-003 Port clk SHALL be an input, 1 bit wide, and serve as the rising-edge clock.
REQ-004 Port reset SHALL be an input, 1 bit wide; reset is synchronous and active-high.
REQ-005 Port enable SHALL be an input, 1 bit wide; when high, it permits starting a new frame.
REQ-006 Port empty SHALL be an input, 1 bit wide, and carry the upstream queue empty flag.
REQ-007 Port q_in SHALL be an input, WIDTH bits wide, and carry the upstream queue registered read data.
REQ-008 Port dequeue SHALL be an output, 1 bit wide, and act as the read strobe to the upstream queue.
REQ-009 Port tx SHALL be an output, 1 bit wide, and carry the serial line, which idles high.
REQ-010 Port busy SHALL be an output, 1 bit wide, and be high in any state other than IDLE.
REQ-011 Port frame_done SHALL be an output, 1 bit wide, and pulse for one cycle after the last bit period ends.

Function
REQ-012 The FSM SHALL have four states: IDLE, REQ, LOAD and SHIFT.
REQ-013 IDLE SHALL go to REQ when enable=1 and empty=0; otherwise it SHALL stay in IDLE.
REQ-014 dequeue SHALL be 1 only in REQ, for exactly one cycle per frame, and REQ SHALL always go to LOAD.
REQ-015 LOAD SHALL capture q_in into the shift register, because the queue updates q on the edge that samples dequeue, and then go to SHIFT.
REQ-016 In SHIFT, tx SHALL equal shreg[0], sending LSB first.
REQ-017 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, after which shreg shifts right by 1 and the bit counter increments.
REQ-018 After bit WIDTH-1 has been held for its full period, frame_done SHALL be 1 for one cycle and the FSM SHALL go to IDLE.
REQ-019 tx SHALL be 1 in IDLE, REQ and LOAD.
REQ-020 Latency: if REQ is in cycle t, bit 0 SHALL appear on tx from cycle t+2, and the frame SHALL occupy WIDTH*CLKS_PER_BIT cycles.
REQ-021 Back-to-back: if enable=1 and empty=0 in the IDLE cycle after frame_done, the FSM SHALL enter REQ on the next edge, giving a minimum 3-cycle gap of tx high between frames.
REQ-022 Deasserting enable after IDLE SHALL NOT abort a frame; the frame SHALL complete and no new REQ SHALL occur.
REQ-023 A change of empty after REQ SHALL be ignored for the current frame.
REQ-024 Counter widths SHALL be $clog2(CLKS_PER_BIT) and $clog2(WIDTH+1), and counters SHALL reset to 0 at every bit or frame boundary with no wrap overflow.
REQ-025 The block SHALL NOT assert dequeue while empty=1 was sampled in the same IDLE decision cycle.

Reset
REQ-026 reset=1 SHALL force, at the next edge: state=IDLE, tx=1, dequeue=0, busy=0, frame_done=0, and shreg and counters to 0.
REQ-027 Reset mid-frame SHALL abandon the frame without emitting frame_done, and tx SHALL be 1 from the next cycle.
REQ-028 reset SHALL take priority over all other inputs.

Structure
REQ-029 Package frame_tx_pkg SHALL hold the state enum (IDLE, REQ, LOAD, SHIFT) and the default constants WIDTH_DEF=11 and CLKS_PER_BIT_DEF=16.
REQ-030 Sub-module bit_timer SHALL be a cycle counter with clk, reset and run inputs and a tick output that pulses every CLKS_PER_BIT cycles while run=1, restarting from 0 when run falls.
REQ-031 All outputs SHALL be registered.

Verification (WIDTH=11, CLKS_PER_BIT=4)
REQ-032 Single frame: queue holds 11'h5A5, enable=1 -> one dequeue pulse, then tx sequence 1,0,1,0,0,1,0,1,1,0,1 with each bit held 4 cycles, and frame_done 44 cycles after bit 0 starts.
REQ-033 Empty hold-off: empty=1 and enable=1 for 50 cycles -> dequeue=0, tx=1 and busy=0 throughout.
REQ-034 Back-to-back: queue holds 11'h001 then 11'h7FE -> exactly two dequeue pulses, two frames, and 3 cycles of tx high between them.
REQ-035 Enable drop: enable falls at bit 3 of 11'h2AA -> the frame completes with frame_done, and no further dequeue occurs while queue empty=0.
REQ-036 Reset mid-frame: reset is pulsed at bit 5 -> tx=1, busy=0 and frame_done=0 next cycle, and a fresh frame starts correctly after release.

Source files
------------

// File: rtl/frame_tx_pkg.sv
// ============================================================================
// Module      : frame_tx_pkg
// Description : Shared state encoding and default sizing for the frame
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_tx_pkg;

    localparam int WIDTH_DEF        = 11;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/frame_tx_bit_timer.sv
// ============================================================================
// Module      : bit_timer
// Description : Free-running cycle counter that ticks once every CLKS_PER_BIT
//               cycles while run is high and restarts when run drops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_timer
    import frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Clearing on tick keeps the count inside 0..CLKS_PER_BIT-1 with no wrap.
    always_comb begin
        cnt_d = '0;
        if (run && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_tx.sv
// ============================================================================
// Module      : frame_tx
// Description : Pulls one word from an upstream queue and shifts it out LSB
//               first, each bit held CLKS_PER_BIT cycles; line idles high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_tx
    import frame_tx_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             empty,
    input  logic [WIDTH-1:0] q_in,
    output logic             dequeue,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BIT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic               done_d;
    logic               tick;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .run   (state_q == SHIFT),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = LOAD;
            end
            // The queue presents the dequeued word one edge after the strobe.
            LOAD: begin
                shreg_d  = q_in;
                bitcnt_d = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bitcnt_q == BIT_W'(WIDTH - 1)) begin
                        bitcnt_d = '0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            tx         <= 1'b1;
            dequeue    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            tx         <= (state_d == SHIFT) ? shreg_d[0] : 1'b1;
            dequeue    <= (state_d == REQ);
            busy       <= (state_d != IDLE);
            frame_done <= done_d;
        end
    end

endmodule

`default_nettype wire
